// File: rtl/cam_gray_capture.sv
// OV7670 RGB444 capture front end: pairs camera bytes into pixels and emits 4-bit luma in raster order.
// Define LUMA_WEIGHTED_EN for (5R+9G+2B)>>4 luma; otherwise (R+2G+B)>>2 is used.
module cam_gray_capture #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic        vsync_i,
    input  logic        href_i,
    input  logic [7:0]  d_i,
    output logic [3:0]  pixel_out_o,
    output logic        out_valid_o,
    output logic        frame_start_o,
    output logic        frame_done_o,
    output logic        line_err_o,
    output logic [18:0] pix_count_o,
    output logic        busy_o
);

    localparam int unsigned COL_W = $clog2(WIDTH + 1);
    localparam int unsigned ROW_W = $clog2(HEIGHT + 1);
    localparam int unsigned PIX_W = 19;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_VSYNC,
        S_CAPTURE,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic               href_q, href_d;
    logic               phase_q, phase_d;
    logic [3:0]         r_q, r_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               col_ovf_q, col_ovf_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               row_ovf_q, row_ovf_d;
    logic [3:0]         pixel_q, pixel_d;
    logic               valid_q, valid_d;
    logic               fstart_q, fstart_d;
    logic               fdone_q, fdone_d;
    logic               err_q, err_d;
    logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic               busy_q, busy_d;

    function automatic logic [3:0] luma(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
`ifdef LUMA_WEIGHTED_EN
        logic [7:0] acc;
        acc = 8'(r) * 8'd5 + 8'(g) * 8'd9 + 8'(b) * 8'd2;
        return 4'(acc >> 4);
`else
        logic [5:0] acc;
        acc = 6'(r) + {1'b0, g, 1'b0} + 6'(b);
        return 4'(acc >> 2);
`endif
    endfunction

    // Next-state, byte pairing, line/frame accounting
    always_comb begin
        state_d   = state_q;
        href_d    = href_i;
        phase_d   = phase_q;
        r_d       = r_q;
        col_d     = col_q;
        col_ovf_d = col_ovf_q;
        row_d     = row_q;
        row_ovf_d = row_ovf_q;
        pixel_d   = pixel_q;
        valid_d   = 1'b0;
        fstart_d  = 1'b0;
        fdone_d   = 1'b0;
        err_d     = err_q;
        pix_cnt_d = pix_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (enable_i) state_d = S_ARM;
            end
            S_ARM: begin
                if (vsync_i) state_d = S_WAIT_VSYNC;
            end
            S_WAIT_VSYNC: begin
                // Entered only after vsync was seen high, so low here is the falling edge
                if (!vsync_i) begin
                    state_d   = S_CAPTURE;
                    fstart_d  = 1'b1;
                    pix_cnt_d = '0;
                    err_d     = 1'b0;
                    col_d     = '0;
                    col_ovf_d = 1'b0;
                    row_d     = '0;
                    row_ovf_d = 1'b0;
                    phase_d   = 1'b0;
                end
            end
            S_CAPTURE: begin
                if (href_i) begin
                    phase_d = ~phase_q;
                    if (!phase_q) begin
                        r_d = d_i[3:0];
                    end else if (col_q == COL_W'(WIDTH)) begin
                        col_ovf_d = 1'b1;
                    end else begin
                        col_d = col_q + COL_W'(1);
                        if (row_q != ROW_W'(HEIGHT)) begin
                            valid_d   = 1'b1;
                            pixel_d   = luma(r_q, d_i[7:4], d_i[3:0]);
                            pix_cnt_d = pix_cnt_q + PIX_W'(1);
                        end
                    end
                end else begin
                    phase_d = 1'b0;
                    if (href_q) begin
                        if (col_q != COL_W'(WIDTH) || col_ovf_q) err_d = 1'b1;
                        col_d     = '0;
                        col_ovf_d = 1'b0;
                        if (row_q == ROW_W'(HEIGHT)) row_ovf_d = 1'b1;
                        else                         row_d     = row_q + ROW_W'(1);
                    end
                end
                // Row check sees the line closed in this same cycle
                if (vsync_i) begin
                    state_d = S_DONE;
                    fdone_d = 1'b1;
                    if (row_d != ROW_W'(HEIGHT) || row_ovf_d) err_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = enable_i ? S_ARM : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_WAIT_VSYNC) || (state_d == S_CAPTURE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            href_q    <= 1'b0;
            phase_q   <= 1'b0;
            r_q       <= '0;
            col_q     <= '0;
            col_ovf_q <= 1'b0;
            row_q     <= '0;
            row_ovf_q <= 1'b0;
            pixel_q   <= '0;
            valid_q   <= 1'b0;
            fstart_q  <= 1'b0;
            fdone_q   <= 1'b0;
            err_q     <= 1'b0;
            pix_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            href_q    <= href_d;
            phase_q   <= phase_d;
            r_q       <= r_d;
            col_q     <= col_d;
            col_ovf_q <= col_ovf_d;
            row_q     <= row_d;
            row_ovf_q <= row_ovf_d;
            pixel_q   <= pixel_d;
            valid_q   <= valid_d;
            fstart_q  <= fstart_d;
            fdone_q   <= fdone_d;
            err_q     <= err_d;
            pix_cnt_q <= pix_cnt_d;
            busy_q    <= busy_d;
        end
    end

    assign pixel_out_o   = pixel_q;
    assign out_valid_o   = valid_q;
    assign frame_start_o = fstart_q;
    assign frame_done_o  = fdone_q;
    assign line_err_o    = err_q;
    assign pix_count_o   = pix_cnt_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_cam_gray_capture.sv
// Directed bench for cam_gray_capture on a 4x2 frame; expected values are hand-computed.
module tb_cam_gray_capture;

    localparam int unsigned W = 4;
    localparam int unsigned H = 2;

`ifdef LUMA_WEIGHTED_EN
    localparam int E_R = 4;
    localparam int E_G = 8;
    localparam int E_B = 1;
`else
    localparam int E_R = 3;
    localparam int E_G = 7;
    localparam int E_B = 3;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        vsync;
    logic        href;
    logic [7:0]  d;
    logic [3:0]  pixel_out;
    logic        out_valid;
    logic        frame_start;
    logic        frame_done;
    logic        line_err;
    logic [18:0] pix_count;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int vcnt = 0;
    int fs_cnt = 0;
    int fd_cnt = 0;
    int consec = 0;
    logic prev_v = 1'b0;
    logic [3:0] pq[$];

    always #5 clk = ~clk;

    cam_gray_capture #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .enable_i      (enable),
        .vsync_i       (vsync),
        .href_i        (href),
        .d_i           (d),
        .pixel_out_o   (pixel_out),
        .out_valid_o   (out_valid),
        .frame_start_o (frame_start),
        .frame_done_o  (frame_done),
        .line_err_o    (line_err),
        .pix_count_o   (pix_count),
        .busy_o        (busy)
    );

    // Output monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (out_valid) begin
            vcnt++;
            pq.push_back(pixel_out);
            if (prev_v) consec++;
        end
        prev_v = out_valid;
        if (frame_start) fs_cnt++;
        if (frame_done)  fd_cnt++;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_begin();
        vsync = 1'b1;
        href  = 1'b0;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (2) tick();
    endtask

    task automatic frame_end();
        href  = 1'b0;
        vsync = 1'b1;
        repeat (3) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        href = 1'b1;
        d    = b;
        tick();
    endtask

    task automatic send_line(input int nbytes, input logic [7:0] b0, input logic [7:0] b1, input int gap);
        for (int i = 0; i < nbytes; i++) send_byte((i % 2 == 0) ? b0 : b1);
        href = 1'b0;
        d    = 8'h00;
        repeat (gap) tick();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_pixel"},  int'(pixel_out), 0);
        check({tag, "_valid"},  int'(out_valid), 0);
        check({tag, "_fstart"}, int'(frame_start), 0);
        check({tag, "_fdone"},  int'(frame_done), 0);
        check({tag, "_err"},    int'(line_err), 0);
        check({tag, "_count"},  int'(pix_count), 0);
        check({tag, "_busy"},   int'(busy), 0);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        vsync  = 1'b0;
        href   = 1'b0;
        d      = 8'h00;
        repeat (3) tick();
        check_outputs_zero("reset");
        reset = 1'b0;
        tick();

        // White frame
        enable = 1'b1;
        vcnt = 0;
        pq.delete();
        frame_begin();
        check("white_fstart", fs_cnt, 1);
        check("white_busy", int'(busy), 1);
        send_line(8, 8'h0F, 8'hFF, 2);
        send_line(8, 8'h0F, 8'hFF, 2);
        check("white_vcnt", vcnt, 8);
        for (int i = 0; i < pq.size(); i++) check("white_pix", int'(pq[i]), 15);
        check("white_count", int'(pix_count), 8);
        check("white_err", int'(line_err), 0);
        frame_end();
        check("white_fdone", fd_cnt, 1);

        // Colour decode, last line ends together with vsync rising
        frame_begin();
        pq.delete();
        send_byte(8'h0F); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'hF0);
        send_byte(8'h00); send_byte(8'h0F);
        send_byte(8'h0F); send_byte(8'hFF);
        href = 1'b0;
        repeat (2) tick();
        send_line(8, 8'h0F, 8'hFF, 0);
        frame_end();
        check("col_size", pq.size(), 8);
        check("col_red",   int'(pq[0]), E_R);
        check("col_green", int'(pq[1]), E_G);
        check("col_blue",  int'(pq[2]), E_B);
        check("col_white", int'(pq[3]), 15);
        check("col_err", int'(line_err), 0);
        check("col_count", int'(pix_count), 8);
        check("col_fdone", fd_cnt, 2);

        // Short line
        frame_begin();
        vcnt = 0;
        send_line(6, 8'h0F, 8'hFF, 2);
        check("short_vcnt", vcnt, 3);
        check("short_err", int'(line_err), 1);
        send_line(8, 8'h0F, 8'hFF, 2);
        check("short_vcnt2", vcnt, 7);
        check("short_count", int'(pix_count), 7);
        check("short_sticky", int'(line_err), 1);
        frame_end();

        // Long line
        frame_begin();
        check("long_err_clr", int'(line_err), 0);
        vcnt = 0;
        send_line(10, 8'h0F, 8'hFF, 2);
        check("long_vcnt", vcnt, 4);
        check("long_err", int'(line_err), 1);
        send_line(8, 8'h0F, 8'hFF, 2);
        check("long_count", int'(pix_count), 8);
        frame_end();

        // Odd byte; enable dropped mid-frame so DONE returns to IDLE
        frame_begin();
        pq.delete();
        send_line(9, 8'h0F, 8'h00, 2);
        check("odd_size", pq.size(), 4);
        for (int i = 0; i < pq.size(); i++) check("odd_pix", int'(pq[i]), E_R);
        enable = 1'b0;
        pq.delete();
        send_line(8, 8'h00, 8'hF0, 2);
        check("odd_size2", pq.size(), 4);
        for (int i = 0; i < pq.size(); i++) check("odd_phase", int'(pq[i]), E_G);
        check("odd_err", int'(line_err), 0);
        check("odd_count", int'(pix_count), 8);
        frame_end();
        check("odd_fdone", fd_cnt, 5);
        check("odd_idle_busy", int'(busy), 0);

        // Arm while vsync low mid-frame: nothing until a full vsync high->low
        vsync = 1'b0;
        repeat (2) tick();
        enable = 1'b1;
        tick();
        vcnt = 0;
        send_line(8, 8'h0F, 8'hFF, 2);
        check("arm_novalid", vcnt, 0);
        check("arm_nofstart", fs_cnt, 5);
        check("arm_busy", int'(busy), 0);
        frame_begin();
        check("arm_fstart", fs_cnt, 6);
        send_line(8, 8'h0F, 8'hFF, 2);
        check("arm_vcnt", vcnt, 4);

        // Reset mid-capture
        enable = 1'b0;
        send_byte(8'h0F);
        send_byte(8'hFF);
        reset = 1'b1;
        href  = 1'b0;
        tick();
        check_outputs_zero("midrst");
        reset = 1'b0;
        vsync = 1'b1;
        repeat (4) tick();
        check("midrst_nofdone", fd_cnt, 5);
        check("no_back_to_back", consec, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_gray_capture.md
# cam_gray_capture

Camera capture front end for the image-processing pipeline. It samples an OV7670-style RGB444 byte stream (vsync/href/8-bit data), pairs bytes into pixels, and converts each pixel to 4-bit luma. It emits one valid-qualified grayscale pixel per pair in raster order, plus a one-cycle frame-start pulse. That pulse drives the frame reset of the downstream 3x3 de-noise stage, and the pixel stream feeds its `pixel_in`/`in_valid`.

## Interface
- `WIDTH`, 640: active pixels per line
- `HEIGHT`, 480: active lines per frame
- `clk` in 1: camera pixel clock; all logic on posedge
- `reset` in 1: synchronous, active-high
- `enable` in 1: arms capture; sampled at frame boundaries only
- `vsync` in 1: camera vertical sync, high between frames
- `href` in 1: camera line valid, high during active bytes
- `d` in 8: camera data byte
- `pixel_out` out 4: luma of the completed pixel
- `out_valid` out 1: `pixel_out` valid this cycle
- `frame_start` out 1: one-cycle pulse at the start of a captured frame
- `frame_done` out 1: one-cycle pulse when a frame ends
- `line_err` out 1: sticky; a line had ≠ `WIDTH` pixels, or the frame had ≠ `HEIGHT` lines
- `pix_count` out 19: pixels emitted in the current frame
- `busy` out 1: high in WAIT_VSYNC and CAPTURE

## Operation
- States:
  - IDLE: `enable`=1 → ARM.
  - ARM: wait for `vsync`=1 → WAIT_VSYNC. This guarantees a full frame.
  - WAIT_VSYNC: `vsync` 1→0 → CAPTURE, assert `frame_start`, clear `pix_count`, `line_err`, row and column counters.
  - CAPTURE: `vsync` 0→1 → DONE.
  - DONE: assert `frame_done` for one cycle. Then go to ARM if `enable`=1, else IDLE.
- Byte pairing, in CAPTURE with `href`=1:
  - The phase bit toggles every cycle.
  - First byte: `R=d[3:0]`. Second byte: `G=d[7:4]`, `B=d[3:0]`.
  - The phase bit clears whenever `href`=0. A dangling odd byte at line end is discarded.
- Line accounting:
  - The column counter counts completed pixels and clears on `href` falling.
  - On `href` falling: if column ≠ `WIDTH`, set `line_err`. The row counter increments.
- Clipping:
  - Pixels with column ≥ `WIDTH` or row ≥ `HEIGHT` are not emitted.
  - Counters saturate at `WIDTH` / `HEIGHT`.
- On CAPTURE exit, if row ≠ `HEIGHT`, set `line_err`.
- `pix_count` increments with each `out_valid`. Maximum is `WIDTH*HEIGHT`.
- Luma arithmetic: see Configuration. The result is always a 4-bit value, truncated (no rounding).
- `enable` deassert mid-frame: the current frame completes. The return to IDLE happens at DONE.

## Timing
- `reset`: all state → IDLE. Output reset values:
  - `pixel_out`=0, `out_valid`=0
  - `frame_start`=0, `frame_done`=0
  - `line_err`=0, `pix_count`=0, `busy`=0
- Reset mid-frame aborts immediately. No `frame_done` pulse is issued.
- Output latency: `out_valid`/`pixel_out` are registered and assert the cycle after the second byte is sampled.
- Maximum output rate is one pixel every two cycles. `out_valid` is never high on consecutive cycles.
- No backpressure. Downstream must accept every valid pixel.
- `frame_start` asserts in the cycle after `vsync` is sampled low. It precedes the first `out_valid` by ≥2 cycles.
- `frame_done` asserts in the cycle after `vsync` is sampled high in CAPTURE.
- Simultaneous `href` falling and `vsync` rising: the line is accounted first, then the frame ends in the same cycle.

## Configuration
- `LUMA_WEIGHTED_EN` defined: `Y = (5R + 9G + 2B) >> 4`, computed with an 8-bit intermediate.
- `LUMA_WEIGHTED_EN` undefined: `Y = (R + 2G + B) >> 2`, computed with a 6-bit intermediate.

## Test plan
- White frame: bytes 0x0F, 0xFF repeated, with `WIDTH`=4, `HEIGHT`=2 → eight pulses of `out_valid` with `pixel_out`=15; then `frame_done`; `pix_count`=8; `line_err`=0.
- Colour decode:
  - Pair 0x0F, 0x00 → `pixel_out`=4 weighted, 3 unweighted.
  - Pair 0x00, 0xF0 → 8 weighted, 7 unweighted.
  - Pair 0x00, 0x0F → 1 weighted, 3 unweighted.
- Short line: one line of 3 pixels, with `WIDTH`=4 → `line_err`=1 after that `href` falling edge; the other pixels are still emitted.
- Long line: 5 pixels, with `WIDTH`=4 → only 4 `out_valid` pulses for that line; `line_err`=1.
- Odd byte: `href` high for 9 bytes → 4 pixels emitted; the 9th byte is discarded; the next line starts on phase 0.
- Arming and reset:
  - `enable` raised while `vsync`=0 mid-frame → no output until the next full `vsync` high→low.
  - `reset` mid-CAPTURE → all outputs 0 next cycle; no `frame_done`.
